// File: rtl/inst_issue_queue.sv
// Multi-lane circular instruction buffer between fetch and dispatch.
// Redirects empty it, raise a one-cycle redirect pulse and count the discarded instructions.
module inst_issue_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES*XLEN-1:0]    in_pc,
  input  logic [LANES*XLEN-1:0]    in_ins,
  input  logic [LANES-1:0]         in_valid,
  output logic                     in_ready,
  output logic [LANES*XLEN-1:0]    out_pc,
  output logic [LANES*XLEN-1:0]    out_ins,
  output logic [LANES-1:0]         out_valid,
  input  logic                     ROB_full,
  input  logic                     flush_en,
  input  logic [XLEN-1:0]          flush_PC,
  input  logic                     branch_en,
  input  logic [XLEN-1:0]          branch_PC,
  input  logic                     jump_en,
  input  logic [XLEN-1:0]          jump_PC,
  output logic                     redirect_en,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              dropped_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW-1:0]   wr_idx [LANES];
  logic [AW-1:0]   rd_idx [LANES];
  logic [CW-1:0]   e_cnt, e_eff, d_cnt;
  logic            redirect, wr_go, stop;
  logic [16:0]     drop_sum;

  // Handshake: a lane is accepted when in_valid is part of the contiguous prefix from lane 0,
  // in_ready (registered occupancy only) is high and no redirect is present; an output lane is
  // consumed when out_valid is high and ROB_full is low with no redirect present.
  assign redirect = flush_en | branch_en | jump_en;
  assign in_ready = (CW'(DEPTH) - occupancy) >= CW'(LANES);
  assign wr_go    = in_ready & ~redirect;
  assign e_eff    = wr_go ? e_cnt : '0;
  assign drop_sum = {1'b0, dropped_cnt} + 17'(occupancy) + 17'(e_cnt);

  always_comb begin
    e_cnt = '0;
    stop  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!stop && in_valid[i]) e_cnt = CW'(i + 1);
      else                      stop  = 1'b1;
    end
  end

  always_comb begin
    d_cnt = '0;
    if (!ROB_full && !redirect)
      d_cnt = (occupancy > CW'(LANES)) ? CW'(LANES) : occupancy;
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      wr_idx[i] = wr_ptr + AW'(i);
      rd_idx[i] = rd_ptr + AW'(i);
    end
  end

  // Invalid lanes drive zeros so stale storage never leaks to dispatch.
  always_comb begin
    out_pc    = '0;
    out_ins   = '0;
    out_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      if (occupancy > CW'(i)) begin
        out_valid[i]              = 1'b1;
        out_pc[i*XLEN +: XLEN]    = pc_mem[rd_idx[i]];
        out_ins[i*XLEN +: XLEN]   = ins_mem[rd_idx[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int i = 0; i < LANES; i++) begin
        if (CW'(i) < e_cnt) begin
          pc_mem[wr_idx[i]]  <= in_pc[i*XLEN +: XLEN];
          ins_mem[wr_idx[i]] <= in_ins[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occupancy   <= '0;
      redirect_en <= 1'b0;
      redirect_pc <= '0;
      dropped_cnt <= '0;
    end else if (redirect) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occupancy   <= '0;
      redirect_en <= 1'b1;
      // flush outranks branch, branch outranks jump
      redirect_pc <= flush_en ? flush_PC : (branch_en ? branch_PC : jump_PC);
      dropped_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end else begin
      rd_ptr      <= rd_ptr + d_cnt[AW-1:0];
      wr_ptr      <= wr_ptr + e_eff[AW-1:0];
      occupancy   <= occupancy + e_eff - d_cnt;
      redirect_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Bench for inst_issue_queue: reset checks, a vector table, directed corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_inst_issue_queue;
  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [LANES*XLEN-1:0] in_pc, in_ins, out_pc, out_ins;
  logic [LANES-1:0]      in_valid, out_valid;
  logic                  in_ready, ROB_full;
  logic                  flush_en, branch_en, jump_en;
  logic [XLEN-1:0]       flush_PC, branch_PC, jump_PC;
  logic                  redirect_en;
  logic [XLEN-1:0]       redirect_pc;
  logic [3:0]            occupancy;
  logic [15:0]           dropped_cnt;

  always #5 clk = ~clk;

  inst_issue_queue #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_pc(in_pc), .in_ins(in_ins), .in_valid(in_valid), .in_ready(in_ready),
    .out_pc(out_pc), .out_ins(out_ins), .out_valid(out_valid),
    .ROB_full(ROB_full),
    .flush_en(flush_en), .flush_PC(flush_PC),
    .branch_en(branch_en), .branch_PC(branch_PC),
    .jump_en(jump_en), .jump_PC(jump_PC),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .occupancy(occupancy), .dropped_cnt(dropped_cnt)
  );

  // Reference model: program-order queue of held entries plus redirect bookkeeping.
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [15:0] m_drop;
  logic        m_ren;
  logic [31:0] m_rpc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  vld;
    logic        rob, fl, br, jp;
    logic [3:0]  occ;
    logic [1:0]  ov;
    logic        rdy;
    logic        ren;
    logic [31:0] rpc;
    logic [15:0] drop;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] lane_pc(input int i);
    return out_pc[i*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] lane_ins(input int i);
    return out_ins[i*XLEN +: XLEN];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drop = '0;
    m_ren  = 1'b0;
    m_rpc  = '0;
  endtask

  task automatic model_edge(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                            input logic rob, input logic fl, input logic br, input logic jp);
    int e, sz, d, tot;
    e  = v[0] ? (v[1] ? 2 : 1) : 0;
    sz = mq.size();
    if (fl || br || jp) begin
      tot    = int'(m_drop) + sz + e;
      m_drop = (tot > 65535) ? 16'hFFFF : 16'(tot);
      mq.delete();
      m_ren  = 1'b1;
      m_rpc  = fl ? flush_PC : (br ? branch_PC : jump_PC);
    end else begin
      m_ren = 1'b0;
      if (!rob) begin
        d = (sz < LANES) ? sz : LANES;
        repeat (d) void'(mq.pop_front());
      end
      if (DEPTH - sz >= LANES) begin
        if (e >= 1) mq.push_back('{p0, ins_of(p0)});
        if (e == 2) mq.push_back('{p1, ins_of(p1)});
      end
    end
  endtask

  task automatic model_check();
    logic [1:0] ev;
    ev = '0;
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("in_ready", 64'(in_ready), 64'((DEPTH - mq.size()) >= LANES));
    for (int i = 0; i < LANES; i++) begin
      if (i < mq.size()) begin
        ev[i] = 1'b1;
        chk($sformatf("out_pc%0d", i), 64'(lane_pc(i)), 64'(mq[i].pc));
        chk($sformatf("out_ins%0d", i), 64'(lane_ins(i)), 64'(mq[i].ins));
      end else begin
        chk($sformatf("out_pc%0d_zero", i), 64'(lane_pc(i)), 64'h0);
      end
    end
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("redirect_en", 64'(redirect_en), 64'(m_ren));
    chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
    chk("dropped_cnt", 64'(dropped_cnt), 64'(m_drop));
  endtask

  task automatic cycle(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic rob, input logic fl, input logic br, input logic jp);
    in_valid  = v;
    in_pc     = {p1, p0};
    in_ins    = {ins_of(p1), ins_of(p0)};
    ROB_full  = rob;
    flush_en  = fl;
    branch_en = br;
    jump_en   = jp;
    model_edge(v, p0, p1, rob, fl, br, jp);
    @(posedge clk);
    #1;
    model_check();
  endtask

  initial begin
    logic [31:0] pc, exp_pc;

    tbl[0]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 2'b01, 1'b1, 1'b0, 32'h000, 16'd0};
    tbl[1]  = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 2'b01, 1'b1, 1'b0, 32'h000, 16'd0};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 1'b1, 1'b0, 32'h000, 16'd0};
    tbl[3]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 2'b11, 1'b1, 1'b0, 32'h000, 16'd0};
    tbl[4]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 2'b11, 1'b1, 1'b0, 32'h000, 16'd0};
    tbl[5]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 2'b11, 1'b1, 1'b0, 32'h000, 16'd0};
    tbl[6]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 2'b11, 1'b1, 1'b0, 32'h000, 16'd0};
    tbl[7]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 2'b00, 1'b1, 1'b1, 32'h200, 16'd8};
    tbl[8]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 32'h200, 16'd8};
    tbl[9]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 2'b00, 1'b1, 1'b1, 32'h500, 16'd10};
    tbl[10] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 2'b00, 1'b1, 1'b1, 32'h300, 16'd11};
    tbl[11] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 32'h300, 16'd11};
    tbl[12] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 2'b11, 1'b1, 1'b0, 32'h300, 16'd11};
    tbl[13] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 32'h300, 16'd11};

    // clock/reset
    rst = 1'b0;
    in_valid = '0; in_pc = '0; in_ins = '0; ROB_full = 1'b0;
    flush_en = 1'b0; branch_en = 1'b0; jump_en = 1'b0;
    flush_PC = 32'h200; branch_PC = 32'h300; jump_PC = 32'h500;
    model_reset();
    #12;
    chk("rst_occupancy", 64'(occupancy), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_pc", 64'(out_pc), 64'h0);
    chk("rst_redirect_en", 64'(redirect_en), 64'h0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'h0);
    chk("rst_dropped", 64'(dropped_cnt), 64'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // vector table: prefix enqueue, stall, dequeue, redirect priority and counting
    for (int k = 0; k < 14; k++) begin
      pc = 32'h400 + 32'(k * 8);
      cycle(tbl[k].vld, pc, pc + 32'h4, tbl[k].rob, tbl[k].fl, tbl[k].br, tbl[k].jp);
      chk($sformatf("tbl%0d_occ", k), 64'(occupancy), 64'(tbl[k].occ));
      chk($sformatf("tbl%0d_valid", k), 64'(out_valid), 64'(tbl[k].ov));
      chk($sformatf("tbl%0d_ready", k), 64'(in_ready), 64'(tbl[k].rdy));
      chk($sformatf("tbl%0d_ren", k), 64'(redirect_en), 64'(tbl[k].ren));
      chk($sformatf("tbl%0d_rpc", k), 64'(redirect_pc), 64'(tbl[k].rpc));
      chk($sformatf("tbl%0d_drop", k), 64'(dropped_cnt), 64'(tbl[k].drop));
    end

    // fill to full under stall, overflow push ignored
    for (int k = 0; k < 4; k++)
      cycle(2'b11, 32'h100 + 32'(k * 8), 32'h104 + 32'(k * 8), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_occ", 64'(occupancy), 64'd8);
    chk("full_ready", 64'(in_ready), 64'h0);
    cycle(2'b11, 32'h120, 32'h124, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_push_ignored", 64'(occupancy), 64'd8);

    // drain in program order
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_pc0", k), 64'(lane_pc(0)), 64'(32'h100 + 32'(k * 8)));
      chk($sformatf("drain%0d_pc1", k), 64'(lane_pc(1)), 64'(32'h104 + 32'(k * 8)));
      cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("drain_empty", 64'(out_valid), 64'h0);

    // steady-state wrap: enqueue 2 / dequeue 2 keeps occupancy at 4
    pc = 32'h1000;
    exp_pc = 32'h1000;
    for (int k = 0; k < 2; k++) begin
      cycle(2'b11, pc, pc + 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
      pc += 32'h8;
    end
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("wrap%0d_pc0", k), 64'(lane_pc(0)), 64'(exp_pc));
      chk($sformatf("wrap%0d_pc1", k), 64'(lane_pc(1)), 64'(exp_pc + 32'h4));
      cycle(2'b11, pc, pc + 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
      pc += 32'h8;
      exp_pc += 32'h8;
      chk($sformatf("wrap%0d_occ", k), 64'(occupancy), 64'd4);
    end
    for (int k = 0; k < 2; k++) cycle(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset between edges with occupancy 5
    cycle(2'b11, 32'h600, 32'h604, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 32'h608, 32'h60C, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(2'b01, 32'h610, 32'h614, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_occ", 64'(occupancy), 64'd5);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    chk("async_rst_occ", 64'(occupancy), 64'h0);
    chk("async_rst_drop", 64'(dropped_cnt), 64'h0);
    model_reset();
    #2 rst = 1'b1;
    cycle(2'b01, 32'h700, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_valid", 64'(out_valid), 64'h1);
    chk("post_rst_pc", 64'(lane_pc(0)), 64'h700);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      flush_PC  = $urandom;
      branch_PC = $urandom;
      jump_PC   = $urandom;
      cycle(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
